menu_char_render: RTL and testbench
===================================

// Module: menu_char_render
// PURPOSE
//  Requester side of the menu text-ROM interface. Overlays a 16x16-character, 8x16-pixel text box on the VGA stream.
//  Each pixel's box-relative position drives char_xy to a text ROM (menu_text*) and takes char_code back.
//  char_code addresses an internal font ROM; the selected font bit is painted FG over rgb_in.
//  Sits in the menu layer between timing/background and the mouse overlay.
// PARAMETERS
//  X_POS        300      box left edge, pixels (hcount units)
//  Y_POS        200      box top edge, lines (vcount units)
//  FG_RGB       12'hFFF  normal glyph colour
//  HL_RGB       12'hF80  highlight colour for the selected row while blink phase = 1
//  BLINK_FRAMES 30       frames per blink half-period; legal range 1..255
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous, active-high reset
//  hcount_in    in   11  horizontal counter
//  hsync_in     in   1   hsync
//  hblnk_in     in   1   hblank
//  vcount_in    in   11  vertical counter
//  vsync_in     in   1   vsync
//  vblnk_in     in   1   vblank
//  rgb_in       in   12  background pixel
//  sel_row      in   4   text row to highlight
//  sel_en       in   1   highlight enable
//  char_code    in   7   from text ROM; registered there, valid 1 clk after char_xy
//  char_xy      out  8   {row[3:0], col[3:0]} to text ROM
//  hcount_out   out  11  hcount_in delayed 4
//  hsync_out    out  1   hsync_in delayed 4
//  hblnk_out    out  1   hblnk_in delayed 4
//  vcount_out   out  11  vcount_in delayed 4
//  vsync_out    out  1   vsync_in delayed 4
//  vblnk_out    out  1   vblnk_in delayed 4
//  rgb_out      out  12  composited pixel, aligned with the *_out signals
// BEHAVIOUR
//  Reset: all outputs, delay taps, blink counter and blink_phase = 0.
//  Geometry:
//   rel_x = hcount_in - X_POS; rel_y = vcount_in - Y_POS (11-bit, wraps).
//   in_box = hcount_in >= X_POS && hcount_in < X_POS+128 && vcount_in >= Y_POS && vcount_in < Y_POS+256.
//   Use unsigned compares. Do not test the sign of rel_x/rel_y.
//  Pipeline (T = input cycle):
//   T+1: char_xy <= {rel_y[7:4], rel_x[6:3]}, registered and driven every cycle even outside the box.
//   T+2: char_code valid; font addr = {char_code, line} with line = rel_y[3:0] delayed 2.
//   T+3: font ROM registered row (8b).
//   T+4: rgb_out registered.
//   Timing signals, in_box, bit index (rel_x[2:0]) and row (rel_y[7:4]) travel in matched delay lines.
//  Pixel select:
//   bit = font_row[7 - col_bit]; MSB is the leftmost pixel.
//   Paint if in_box && bit && !hblnk && !vblnk; otherwise rgb_out = rgb_in delayed 4.
//   Colour = HL_RGB if sel_en && row == sel_row && blink_phase, else FG_RGB.
//   sel_row/sel_en are sampled at T with the pixel, so a change applies from the next pixel.
//  Blink:
//   frame_cnt (8b) increments on each vsync_in rising edge (prev-value register).
//   When it reaches BLINK_FRAMES-1 on an edge: frame_cnt <= 0, blink_phase toggles.
//   With BLINK_FRAMES = 1, blink_phase toggles every frame.
//  Boundaries:
//   Box edge pixels at X_POS and X_POS+127 are inside; X_POS+128 is outside.
//   rel_x wraps when hcount_in < X_POS; in_box must be 0 there.
//   Reset mid-frame clears the pipeline. Outputs are 0 for 4 clk after rst falls, then track the input.
//   No handshake: the text ROM must have exactly 1-clk latency.
// STRUCTURE
//  vga_pkg gains: MENU_CHAR_W = 8, MENU_CHAR_H = 16, MENU_COLS = 16, MENU_ROWS = 16, MENU_PIPE_LAT = 4.
//  vga_pkg gains: typedef char_xy_t = struct packed {logic [3:0] row; logic [3:0] col;}.
//  Sub-module menu_font_rom:
//   clk, addr[10:0] -> data[7:0], registered, 1-clk latency, 2048x8 initialised from a .data file.
//  Remainder, all in this file: delay lines, blink logic, output mux.
// TESTING
//  1. Reset held 10 clk mid-line:
//     -> all outputs 0.
//     After release: hsync_out equals hsync_in from exactly 4 clk earlier.
//  2. X_POS=300, Y_POS=200, hcount=309, vcount=237:
//     -> char_xy = 8'h21 one clk later.
//  3. Text-ROM model returns code 'A'; font row 8'b1000_0001; hcount=X_POS..X_POS+7:
//     -> rgb_out = FG_RGB at the first and last pixel, rgb_in elsewhere, 4 clk later.
//  4. hcount = X_POS-1 and X_POS+128 with all font bits set:
//     -> rgb_out = rgb_in.
//     Same pixel with hblnk_in = 1 -> rgb_out = rgb_in.
//  5. sel_en=1, sel_row=4, BLINK_FRAMES=2; run 5 vsync pulses:
//     -> blink_phase toggles after the 2nd and 4th vsync pulses.
//     Row-4 glyph pixels are HL_RGB only while the phase is 1. Row 3 stays FG_RGB.
//  6. Full 800x600 frame vs. reference model:
//     -> zero pixel or timing mismatches; char_xy sweeps 8'h00..8'hFF inside the box.

Source files
------------

// File: rtl/menu_char_render_pkg.sv
// Shared constants, types and glyph contents for the menu text overlay.
package menu_char_render_pkg;

    localparam int unsigned MENU_CHAR_W   = 8;
    localparam int unsigned MENU_CHAR_H   = 16;
    localparam int unsigned MENU_COLS     = 16;
    localparam int unsigned MENU_ROWS     = 16;
    localparam int unsigned MENU_PIPE_LAT = 4;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } char_xy_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef struct packed {
        vga_t       vga;
        logic       in_box;
        logic [2:0] bit_idx;
        logic [3:0] line;
        logic       hl;
    } pix_t;

    // Glyph contents are generated rather than loaded, so the build needs no data file.
    function automatic logic [7:0] font_glyph_row(logic [6:0] code, logic [3:0] line);
        logic [7:0] row;
        if (line == 4'd0)       row = 8'h81;
        else if (line == 4'd15) row = 8'hFF;
        else                    row = {1'b0, code} * 8'd37 + {4'b0, line} * 8'd11;
        return row;
    endfunction

endpackage

// File: rtl/menu_char_render_if.sv
// Text-ROM lookup bus: character position out, character code back one clock later.
interface menu_char_render_if;
    logic [7:0] char_xy;
    logic [6:0] char_code;

    modport master (output char_xy, input char_code);
    modport slave  (input char_xy, output char_code);
endinterface

// File: rtl/menu_char_render_font_rom.sv
// 2048x8 glyph ROM addressed by {char_code, line}; registered, one clock of latency.
module menu_font_rom
    import menu_char_render_pkg::*;
(
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [7:0] data_d, data_q;

    always_comb data_d = font_glyph_row(addr[10:4], addr[3:0]);

    always_ff @(posedge clk) data_q <= data_d;

    assign data = data_q;

endmodule

// File: rtl/menu_char_render.sv
// Overlays a 16x16 character text box on the VGA stream; four clocks from pixel in to pixel out.
module menu_char_render
    import menu_char_render_pkg::*;
#(
    parameter logic [10:0] X_POS        = 11'd300,
    parameter logic [10:0] Y_POS        = 11'd200,
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] HL_RGB       = 12'hF80,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [3:0]  sel_row,
    input  logic        sel_en,
    menu_char_render_if.master txt,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [6:0]  rel_x;
    logic [7:0]  rel_y;
    logic        in_box;
    logic        paint;
    logic [7:0]  font_row;
    logic [10:0] font_addr;

    pix_t [2:0]  pipe_d, pipe_q;
    char_xy_t    char_xy_d, char_xy_q;
    vga_t        out_d, out_q;
    logic [7:0]  frame_cnt_d, frame_cnt_q;
    logic        blink_phase_d, blink_phase_q;
    logic        vsync_prev_d, vsync_prev_q;

    menu_font_rom u_font_rom (
        .clk  (clk),
        .addr (font_addr),
        .data (font_row)
    );

    always_comb begin
        rel_x  = 7'(hcount_in - X_POS);
        rel_y  = 8'(vcount_in - Y_POS);
        in_box = ({1'b0, hcount_in} >= {1'b0, X_POS}) &&
                 ({1'b0, hcount_in} <  {1'b0, X_POS} + 12'd128) &&
                 ({1'b0, vcount_in} >= {1'b0, Y_POS}) &&
                 ({1'b0, vcount_in} <  {1'b0, Y_POS} + 12'd256);

        char_xy_d = '{row: rel_y[7:4], col: rel_x[6:3]};

        pipe_d[0].vga     = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                              vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                              rgb: rgb_in};
        pipe_d[0].in_box  = in_box;
        pipe_d[0].bit_idx = rel_x[2:0];
        pipe_d[0].line    = rel_y[3:0];
        // Row match is resolved at entry so the row itself need not ride the delay line.
        pipe_d[0].hl      = sel_en && (rel_y[7:4] == sel_row) && blink_phase_q;
        pipe_d[2:1]       = pipe_q[1:0];

        font_addr = {txt.char_code, pipe_q[1].line};

        paint = pipe_q[2].in_box && font_row[3'd7 - pipe_q[2].bit_idx] &&
                !pipe_q[2].vga.hblnk && !pipe_q[2].vga.vblnk;
        out_d = pipe_q[2].vga;
        if (paint) out_d.rgb = pipe_q[2].hl ? HL_RGB : FG_RGB;

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        vsync_prev_d  = vsync_in;
        if (vsync_in && !vsync_prev_q) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q        <= '0;
            char_xy_q     <= '0;
            out_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            vsync_prev_q  <= 1'b0;
        end else begin
            pipe_q        <= pipe_d;
            char_xy_q     <= char_xy_d;
            out_q         <= out_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            vsync_prev_q  <= vsync_prev_d;
        end
    end

    assign txt.char_xy = char_xy_q;
    assign hcount_out  = out_q.hcount;
    assign hsync_out   = out_q.hsync;
    assign hblnk_out   = out_q.hblnk;
    assign vcount_out  = out_q.vcount;
    assign vsync_out   = out_q.vsync;
    assign vblnk_out   = out_q.vblnk;
    assign rgb_out     = out_q.rgb;

endmodule

// File: tb/tb_menu_char_render.sv
// Bench for menu_char_render: per-cycle reference model plus directed literal pixel checks.
module tb_menu_char_render;

    localparam int          X  = 300;
    localparam int          Y  = 200;
    localparam int          BF = 2;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] HL = 12'hF80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [3:0]  sel_row = '0;
    logic        sel_en = 1'b0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    menu_char_render_if txt_if ();

    menu_char_render #(
        .X_POS        (11'd300),
        .Y_POS        (11'd200),
        .FG_RGB       (FG),
        .HL_RGB       (HL),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .vcount_in  (vcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .sel_row    (sel_row),
        .sel_en     (sel_en),
        .txt        (txt_if),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // Text ROM: registered, one clock of latency.
    logic [6:0] text_rom [256];
    always @(posedge clk) txt_if.char_code <= text_rom[txt_if.char_xy];

    function automatic logic [7:0] tb_font(logic [6:0] c, logic [3:0] l);
        if (l == 4'd0)  return 8'h81;
        if (l == 4'd15) return 8'hFF;
        return 8'((int'(c) * 37 + int'(l) * 11) % 256);
    endfunction

    typedef struct {
        bit          rst;
        bit          inb;
        logic [7:0]  xy;
        logic [38:0] out;
    } rec_t;

    rec_t        hist[$];
    int unsigned vs_rises = 0;
    bit          vs_prev = 0;
    bit          seen [256];

    function automatic rec_t model_pix(bit ph);
        rec_t r;
        int hc, vc, relx, rely, row, col, line, bi;
        logic [7:0] fr;
        bit paint;
        logic [11:0] rgb;
        hc   = int'(hcount_in);
        vc   = int'(vcount_in);
        relx = (hc - X + 2048) % 2048;
        rely = (vc - Y + 2048) % 2048;
        r.rst = 0;
        r.inb = (hc >= X) && (hc < X + 128) && (vc >= Y) && (vc < Y + 256);
        r.xy  = 8'(((rely / 16) % 16) * 16 + (relx / 8) % 16);
        paint = 0;
        row   = 0;
        if (r.inb) begin
            row   = rely / 16;
            col   = relx / 8;
            line  = rely % 16;
            bi    = relx % 8;
            fr    = tb_font(text_rom[row * 16 + col], 4'(line));
            paint = (fr[7 - bi] == 1'b1) && !hblnk_in && !vblnk_in;
        end
        rgb = rgb_in;
        if (paint) rgb = (sel_en && int'(sel_row) == row && ph) ? HL : FG;
        r.out = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb};
        return r;
    endfunction

    // Blink phase = parity of (vsync rising edges since reset) / BF.
    always @(posedge clk) begin
        rec_t r;
        bit ph;
        ph = ((vs_rises / BF) % 2) == 1;
        if (rst) begin
            r.rst = 1; r.inb = 0; r.xy = '0; r.out = '0;
            vs_rises = 0;
            vs_prev  = 0;
        end else begin
            r = model_pix(ph);
            if (vsync_in && !vs_prev) vs_rises++;
            vs_prev = vsync_in;
        end
        hist.push_back(r);
        if (hist.size() > 4) void'(hist.pop_front());
    end

    always @(negedge clk) begin
        logic [38:0] exp_out, act_out;
        if (hist.size() == 4) begin
            exp_out = (hist[0].rst || hist[1].rst || hist[2].rst || hist[3].rst) ? '0 : hist[0].out;
            act_out = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
            checks++;
            if (act_out !== exp_out) begin
                errors++;
                $display("FAIL pipe_out t=%0t act %h exp %h", $time, act_out, exp_out);
            end
            checks++;
            if (txt_if.char_xy !== hist[3].xy) begin
                errors++;
                $display("FAIL char_xy t=%0t act %h exp %h", $time, txt_if.char_xy, hist[3].xy);
            end
            if (hist[3].inb) seen[txt_if.char_xy] = 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act %h exp %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          v;
        logic [11:0] e;
        string       nm;
    } lit_t;
    lit_t lq[$];

    // Drive one pixel; check the pixel driven four steps earlier against its literal.
    task automatic step(input int hc, input int vc, input logic hb, input logic vb,
                        input logic vs, input logic [11:0] rgb,
                        input bit v, input logic [11:0] e, input string nm);
        lit_t o;
        @(negedge clk);
        if (lq.size() == 4) begin
            o = lq.pop_front();
            if (o.v) chk(o.nm, 64'(rgb_out), 64'(o.e));
        end
        hcount_in = 11'(hc); vcount_in = 11'(vc);
        hblnk_in = hb; vblnk_in = vb; vsync_in = vs; hsync_in = 1'b0;
        rgb_in = rgb;
        lq.push_back('{v, e, nm});
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 12'h0, 0, 12'h0, "");
    endtask

    initial begin
        logic [11:0] pat;
        logic [11:0] r;
        bit ph;
        int nseen;

        for (int i = 0; i < 256; i++) text_rom[i] = 7'($urandom_range(0, 127));
        text_rom[0] = 7'h41;

        // Reset held mid-line with an active in-box pixel stream.
        hcount_in = 11'd350; vcount_in = 11'd210; rgb_in = 12'hABC;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_zero", {17'b0, txt_if.char_xy, hcount_out, hsync_out, hblnk_out,
                             vcount_out, vsync_out, vblnk_out, rgb_out}, 64'h0);
            hsync_in = ~hsync_in;
        end

        pat = 12'b1011_0011_1010;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                if (i < 4)
                    chk("post_rst_zero", {25'b0, hcount_out, hsync_out, hblnk_out,
                                          vcount_out, vsync_out, vblnk_out, rgb_out}, 64'h0);
                else
                    chk("hsync_delay4", 64'(hsync_out), 64'(pat[i - 4]));
            end
            else @(negedge clk);
            if (i == 0) rst = 1'b0;
            hcount_in = 11'd100; vcount_in = 11'd50;
            hsync_in = pat[i];
            rgb_in = 12'($urandom);
            @(negedge clk);
        end

        // Character position lookup.
        hcount_in = 11'd309; vcount_in = 11'd237;
        @(negedge clk);
        chk("char_xy_309_237", 64'(txt_if.char_xy), 64'h21);

        // Glyph 'A', line 0 = 8'b1000_0001.
        lq.delete();
        for (int k = 0; k < 8; k++) begin
            r = 12'h120 + 12'(k);
            step(X + k, Y, 0, 0, 0, r, 1, (k == 0 || k == 7) ? FG : r, $sformatf("glyph_A_px%0d", k));
        end
        flush();

        // Line 15 has every font bit set.
        step(X - 1,   Y + 15, 0, 0, 0, 12'h111, 1, 12'h111, "left_outside");
        step(X + 128, Y + 15, 0, 0, 0, 12'h222, 1, 12'h222, "right_outside");
        step(X,       Y + 15, 1, 0, 0, 12'h333, 1, 12'h333, "hblnk_inside");
        step(X + 127, Y + 15, 0, 0, 0, 12'h444, 1, FG,      "right_edge_in");
        step(X,       Y + 15, 0, 1, 0, 12'h555, 1, 12'h555, "vblnk_inside");
        step(X,       Y + 15, 0, 0, 0, 12'h666, 1, FG,      "left_edge_in");
        step(X + 1,   Y - 1,  0, 0, 0, 12'h777, 1, 12'h777, "above_box");
        flush();

        // Blink on row 4 with BF = 2.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        lq.delete();
        sel_en = 1'b1; sel_row = 4'd4;
        for (int p = 0; p <= 5; p++) begin
            if (p > 0) begin
                step(0, 0, 0, 0, 1, 12'h0, 0, 12'h0, "");
                step(0, 0, 0, 0, 1, 12'h0, 0, 12'h0, "");
                step(0, 0, 0, 0, 0, 12'h0, 0, 12'h0, "");
            end
            ph = ((p / 2) % 2) == 1;
            step(X + 8, Y + 64 + 15, 0, 0, 0, 12'h0A0, 1, ph ? HL : FG, $sformatf("row4_after%0d", p));
            step(X + 8, Y + 48 + 15, 0, 0, 0, 12'h0B0, 1, FG, $sformatf("row3_after%0d", p));
        end
        flush();

        // Compressed frame covering the whole box.
        for (int i = 0; i < 256; i++) seen[i] = 0;
        for (int vc = 196; vc < 460; vc++) begin
            sel_en  = 1'($urandom);
            sel_row = 4'($urandom);
            for (int hc = 292; hc < 440; hc++) begin
                @(negedge clk);
                hcount_in = 11'(hc); vcount_in = 11'(vc);
                hblnk_in = (hc >= 432); hsync_in = (hc >= 434 && hc < 438);
                vblnk_in = (vc >= 456); vsync_in = (vc >= 457 && vc < 459);
                rgb_in = 12'($urandom);
            end
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
        nseen = 0;
        for (int i = 0; i < 256; i++) nseen += seen[i] ? 1 : 0;
        chk("char_xy_sweep", 64'(nseen), 64'd256);

        // Random stimulus around the box, including occasional mid-frame resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 399) == 0);
            hcount_in = 11'($urandom_range(280, 450));
            vcount_in = 11'($urandom_range(180, 480));
            hsync_in  = 1'($urandom);
            hblnk_in  = ($urandom_range(0, 7) == 0);
            vblnk_in  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) vsync_in = ~vsync_in;
            rgb_in    = 12'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                sel_en  = 1'($urandom);
                sel_row = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
